pcm_mem_responder: RTL and testbench



---
 rtl/pcm_mem_pkg.sv | 32 +++
 rtl/pcm_mem_responder_if.sv | 43 ++++
 rtl/pcm_mem_rdpipe.sv | 43 ++++
 rtl/pcm_mem_responder.sv | 107 ++++++++++
 tb/tb_pcm_mem_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pcm_mem_pkg.sv
// pcm_mem_pkg
// Shared definitions for the PCM shared-memory responder:
//   - default geometry (word address width, data width)
//   - clear-engine state encoding
//   - default clear word
//   - byte-lane merge helper used by byte-enable writes
package pcm_mem_pkg;

    localparam int              DEF_ADDR_W      = 11;
    localparam int              DEF_DATA_W      = 16;
    localparam logic [15:0]     DEF_CLEAR_VALUE = 16'h0000;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } pcm_state_e;

    // Replace only the byte lanes whose enable bit is set.
    // be[1] selects [15:8], be[0] selects [7:0].
    function automatic logic [15:0] merge_bytes(
        input logic [15:0] old_w,
        input logic [15:0] wdata,
        input logic [1:0]  be
    );
        logic [15:0] merged;
        merged       = old_w;
        if (be[1]) merged[15:8] = wdata[15:8];
        if (be[0]) merged[7:0]  = wdata[7:0];
        return merged;
    endfunction

endpackage

// File: rtl/pcm_mem_responder_if.sv
// pcm_mem_responder_if
// Memory-mapped bus between the CPU-side arbiter (master) and the
// responder (slave).
//   pcm_mem_mm_address       master->slave  word address
//   pcm_mem_mm_chipselect    master->slave  access request qualifier
//   pcm_mem_mm_clken         master->slave  global clock enable
//   pcm_mem_mm_write         master->slave  1 = write, 0 = read
//   pcm_mem_mm_writedata     master->slave  write data
//   pcm_mem_mm_byteenable    master->slave  byte lanes for writes
//   pcm_mem_mm_readdata      slave->master  read data
//   pcm_mem_mm_readdatavalid slave->master  one-cycle pulse per read
//
// Handshake: there is no ready/waitrequest. An access is taken at a
// rising edge when chipselect and clken are both high and the responder
// is idle; any access offered while the responder is clearing is
// discarded and flagged on the sticky dropped output. Read data returns
// as a single-cycle readdatavalid pulse a fixed number of enabled cycles
// later, strictly in request order.
interface pcm_mem_responder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] pcm_mem_mm_address;
    logic              pcm_mem_mm_chipselect;
    logic              pcm_mem_mm_clken;
    logic              pcm_mem_mm_write;
    logic [DATA_W-1:0] pcm_mem_mm_writedata;
    logic [1:0]        pcm_mem_mm_byteenable;
    logic [DATA_W-1:0] pcm_mem_mm_readdata;
    logic              pcm_mem_mm_readdatavalid;

    modport master (
        output pcm_mem_mm_address, pcm_mem_mm_chipselect, pcm_mem_mm_clken,
               pcm_mem_mm_write, pcm_mem_mm_writedata, pcm_mem_mm_byteenable,
        input  pcm_mem_mm_readdata, pcm_mem_mm_readdatavalid
    );

    modport slave (
        input  pcm_mem_mm_address, pcm_mem_mm_chipselect, pcm_mem_mm_clken,
               pcm_mem_mm_write, pcm_mem_mm_writedata, pcm_mem_mm_byteenable,
        output pcm_mem_mm_readdata, pcm_mem_mm_readdatavalid
    );
endinterface

// File: rtl/pcm_mem_rdpipe.sv
// pcm_mem_rdpipe
// LATENCY-deep shift register of {valid, data} returning read results.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   en          common stage enable; low freezes every stage
//   in_valid    a read was accepted this cycle
//   in_data     word read from the store at acceptance
//   out_valid   one-cycle pulse when a read completes
//   out_data    read data; holds the last completed read between pulses
module pcm_mem_rdpipe #(
    parameter int DATA_W  = 16,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    logic [LATENCY-1:0] v;
    logic [DATA_W-1:0]  d [LATENCY];

    // Data registers only load behind a valid token, so the last stage
    // keeps the most recent read word while no read is completing.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int i = 0; i < LATENCY; i++) d[i] <= '0;
        end else if (en) begin
            v[0] <= in_valid;
            if (in_valid) d[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) d[i] <= d[i-1];
            end
        end
    end

    assign out_valid = v[LATENCY-1];
    assign out_data  = d[LATENCY-1];
endmodule

// File: rtl/pcm_mem_responder.sv
// pcm_mem_responder
// Word store (2**ADDR_W x 16) behind the PCM shared-memory bus, with
// byte-enable writes, fixed-latency pipelined reads and an init-triggered
// clear sweep.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset (store contents untouched)
//   init       single-cycle pulse starting / restarting a clear sweep
//   bus        pcm_mem_responder_if slave modport
//   busy       clear sweep in progress
//   dropped    sticky; an access arrived while clearing or alongside init
//   state_dbg  current clear-engine state
module pcm_mem_responder
    import pcm_mem_pkg::*;
#(
    parameter int          ADDR_W       = DEF_ADDR_W,
    parameter int          DATA_W       = DEF_DATA_W,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] CLEAR_VALUE  = DEF_CLEAR_VALUE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    pcm_mem_responder_if.slave  bus,
    output logic                busy,
    output logic                dropped,
    output pcm_state_e          state_dbg
);
    localparam int DEPTH = 2 ** ADDR_W;

    pcm_state_e        state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic en;
    logic acc;
    logic wr_acc;
    logic rd_acc;
    logic clr_we;

    assign en = bus.pcm_mem_mm_clken;

    // init wins over a same-cycle access; reset blocks every store write
    // because the store itself is not reset.
    assign acc    = bus.pcm_mem_mm_chipselect & en & (state == IDLE) & ~init & ~reset;
    assign wr_acc = acc & bus.pcm_mem_mm_write;
    assign rd_acc = acc & ~bus.pcm_mem_mm_write;
    // A restart cycle writes nothing; the sweep resumes from 0 next cycle.
    assign clr_we = en & (state == CLEAR) & ~init & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            dropped  <= 1'b0;
            clr_addr <= '0;
        end else if (en) begin
            if (bus.pcm_mem_mm_chipselect && (init || state == CLEAR))
                dropped <= 1'b1;
            case (state)
                IDLE: begin
                    if (init) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    if (init) begin
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                        if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= CLEAR_VALUE;
        else if (wr_acc)
            mem[bus.pcm_mem_mm_address] <= merge_bytes(mem[bus.pcm_mem_mm_address],
                                                       bus.pcm_mem_mm_writedata,
                                                       bus.pcm_mem_mm_byteenable);
    end

    pcm_mem_rdpipe #(
        .DATA_W  (DATA_W),
        .LATENCY (READ_LATENCY)
    ) u_rdpipe (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (rd_acc),
        .in_data   (mem[bus.pcm_mem_mm_address]),
        .out_valid (bus.pcm_mem_mm_readdatavalid),
        .out_data  (bus.pcm_mem_mm_readdata)
    );

    assign state_dbg = state;
endmodule

// File: tb/tb_pcm_mem_responder.sv
// tb_pcm_mem_responder
// Directed bench for pcm_mem_responder with READ_LATENCY = 2. Inputs
// change 1 ns after the rising edge and outputs are sampled at the same
// point, so "after edge k" below means the value visible in cycle k+1.
module tb_pcm_mem_responder;
    import pcm_mem_pkg::*;

    localparam int LAT = 2;

    logic       clk;
    logic       reset;
    logic       init;
    logic       busy;
    logic       dropped;
    pcm_state_e state_dbg;

    int n_assert;
    int n_fail;

    pcm_mem_responder_if #(.ADDR_W(11), .DATA_W(16)) bus ();

    pcm_mem_responder #(
        .ADDR_W       (11),
        .DATA_W       (16),
        .READ_LATENCY (LAT),
        .CLEAR_VALUE  (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .bus       (bus.slave),
        .busy      (busy),
        .dropped   (dropped),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.pcm_mem_mm_chipselect = 1'b0;
        bus.pcm_mem_mm_write      = 1'b0;
        bus.pcm_mem_mm_byteenable = 2'b00;
        init                      = 1'b0;
    endtask

    task automatic do_write(input logic [10:0] a, input logic [15:0] d, input logic [1:0] be);
        bus.pcm_mem_mm_address    = a;
        bus.pcm_mem_mm_writedata  = d;
        bus.pcm_mem_mm_byteenable = be;
        bus.pcm_mem_mm_write      = 1'b1;
        bus.pcm_mem_mm_chipselect = 1'b1;
        tick();
        bus_idle();
    endtask

    // Read with latency 2: nothing after the accept edge, pulse after the
    // next edge, then valid drops while data holds.
    task automatic do_read(input logic [10:0] a, input logic [15:0] exp, input string tag);
        bus.pcm_mem_mm_address    = a;
        bus.pcm_mem_mm_write      = 1'b0;
        bus.pcm_mem_mm_chipselect = 1'b1;
        tick();
        bus_idle();
        chk(32'(bus.pcm_mem_mm_readdatavalid), 32'd0, {tag, "_rdv_early"});
        tick();
        chk(32'(bus.pcm_mem_mm_readdatavalid), 32'd1, {tag, "_rdv"});
        chk(32'(bus.pcm_mem_mm_readdata), 32'(exp), {tag, "_data"});
        tick();
        chk(32'(bus.pcm_mem_mm_readdatavalid), 32'd0, {tag, "_rdv_end"});
        chk(32'(bus.pcm_mem_mm_readdata), 32'(exp), {tag, "_hold"});
    endtask

    // Stall stream table: expected valid/data after each of 8 edges.
    logic        stall_rdv [8];
    logic [15:0] stall_dat [8];

    // ---------------- stimulus ----------------
    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.pcm_mem_mm_address   = '0;
        bus.pcm_mem_mm_writedata = '0;
        bus.pcm_mem_mm_clken     = 1'b1;
        bus_idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        chk(32'(bus.pcm_mem_mm_readdata), 32'h0, "rst_readdata");
        chk(32'(bus.pcm_mem_mm_readdatavalid), 32'h0, "rst_rdv");
        chk(32'(busy), 32'h0, "rst_busy");
        chk(32'(dropped), 32'h0, "rst_dropped");
        chk(32'(state_dbg), 32'(IDLE), "rst_state");

        // 1: full write then read-after-write
        do_write(11'h010, 16'hBEEF, 2'b11);
        do_read(11'h010, 16'hBEEF, "t1");

        // 2: low-lane write, then a no-op write
        do_write(11'h010, 16'h1234, 2'b01);
        do_read(11'h010, 16'hBE34, "t2_lo");
        do_write(11'h010, 16'hFFFF, 2'b00);
        do_read(11'h010, 16'hBE34, "t2_none");
        do_write(11'h010, 16'hA5C3, 2'b10);
        do_read(11'h010, 16'hA534, "t2_hi");

        // 3a: four back-to-back reads
        for (int i = 0; i < 4; i++) do_write(11'(i), 16'hA000 + 16'(i), 2'b11);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                bus.pcm_mem_mm_address    = 11'(i);
                bus.pcm_mem_mm_write      = 1'b0;
                bus.pcm_mem_mm_chipselect = 1'b1;
            end else begin
                bus_idle();
            end
            tick();
            if (i >= 1 && i <= 4) begin
                chk(32'(bus.pcm_mem_mm_readdatavalid), 32'd1, $sformatf("t3_rdv%0d", i));
                chk(32'(bus.pcm_mem_mm_readdata), 32'h0000A000 + 32'(i - 1), $sformatf("t3_dat%0d", i));
            end else begin
                chk(32'(bus.pcm_mem_mm_readdatavalid), 32'd0, $sformatf("t3_rdv%0d", i));
            end
        end
        bus_idle();

        // 3b: same stream with clken low for two edges after the 2nd read
        stall_rdv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        stall_dat = '{16'hA003, 16'hA000, 16'hA000, 16'hA000,
                      16'hA001, 16'hA002, 16'hA003, 16'hA003};
        for (int i = 0; i < 8; i++) begin
            bus_idle();
            bus.pcm_mem_mm_clken = (i == 2 || i == 3) ? 1'b0 : 1'b1;
            if (i == 0 || i == 1 || i == 4 || i == 5) begin
                bus.pcm_mem_mm_address    = (i < 2) ? 11'(i) : 11'(i - 2);
                bus.pcm_mem_mm_chipselect = 1'b1;
            end
            tick();
            chk(32'(bus.pcm_mem_mm_readdatavalid), 32'(stall_rdv[i]), $sformatf("t3s_rdv%0d", i));
            chk(32'(bus.pcm_mem_mm_readdata), 32'(stall_dat[i]), $sformatf("t3s_dat%0d", i));
        end
        bus_idle();
        bus.pcm_mem_mm_clken = 1'b1;

        // 4: full sweep, write while busy is dropped
        do_write(11'h020, 16'h2020, 2'b11);
        do_write(11'h7FF, 16'h7777, 2'b11);
        init = 1'b1;
        tick();
        init = 1'b0;
        chk(32'(busy), 32'd1, "t4_busy_start");
        chk(32'(dropped), 32'd0, "t4_dropped_pre");
        do_write(11'h020, 16'h5555, 2'b11);   // sweep cycle 1
        chk(32'(dropped), 32'd1, "t4_dropped");
        for (int i = 0; i < 2046; i++) tick(); // sweep cycles 2..2047
        chk(32'(busy), 32'd1, "t4_busy_last");
        tick();                                // sweep cycle 2048
        chk(32'(busy), 32'd0, "t4_busy_done");
        chk(32'(state_dbg), 32'(IDLE), "t4_state");
        do_read(11'h000, 16'h0000, "t4_a000");
        do_read(11'h020, 16'h0000, "t4_a020");
        do_read(11'h7FF, 16'h0000, "t4_a7ff");

        // 5: reset when the sweep counter reaches 0x100
        do_write(11'h0FF, 16'h1111, 2'b11);
        do_write(11'h100, 16'h3333, 2'b11);
        do_write(11'h200, 16'h2222, 2'b11);
        init = 1'b1;
        tick();
        init = 1'b0;
        for (int i = 0; i < 256; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk(32'(busy), 32'd0, "t5_busy");
        chk(32'(dropped), 32'd0, "t5_dropped");
        do_read(11'h0FF, 16'h0000, "t5_a0ff");
        do_read(11'h100, 16'h3333, "t5_a100");
        do_read(11'h200, 16'h2222, "t5_a200");

        // 6: read coincident with init is dropped
        bus.pcm_mem_mm_address    = 11'h200;
        bus.pcm_mem_mm_write      = 1'b0;
        bus.pcm_mem_mm_chipselect = 1'b1;
        init = 1'b1;
        tick();
        bus_idle();
        chk(32'(busy), 32'd1, "t6_busy");
        chk(32'(dropped), 32'd1, "t6_dropped");
        chk(32'(bus.pcm_mem_mm_readdatavalid), 32'd0, "t6_rdv0");
        tick();
        chk(32'(bus.pcm_mem_mm_readdatavalid), 32'd0, "t6_rdv1");
        tick();
        chk(32'(bus.pcm_mem_mm_readdatavalid), 32'd0, "t6_rdv2");

        // Bounded wait for the sweep to finish
        begin
            int cyc;
            cyc = 0;
            while (busy && cyc < 3000) begin
                tick();
                cyc++;
            end
            chk(32'(busy), 32'd0, "t6_sweep_end");
        end
        do_read(11'h200, 16'h0000, "t6_a200");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
